uart_ex: RTL

- Parametrised full-duplex UART. Successor to the fixed 8N1, 4x-oversampled UART.
- Adds configurable divider, oversampling ratio, data width, parity and stop bits.
- Adds a 2-FF rx synchroniser and break-safe re-arm, plus parity and framing error reporting.
- Sits between the host serial pins and the command/capture logic; byte-stream handshake unchanged.

---
 rtl/uart_ex.sv | 368 ++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_ex.sv
// -----------------------------------------------------------------------------
// uart_ex : parametrised full-duplex UART.
//
// Frame: start (0), DATA_BITS data LSB first, optional parity, stop bit(s) (1).
// One oversample tick every CLK_DIV_COUNT+1 clocks; OVS = 2**OVS_LOG2 ticks per bit.
//
// Optional build macro UART_RX_MAJORITY_EN: each receive sample is the 2-of-3
// majority of the synchronised line at ticks centre-1/centre/centre+1, and the
// decision (and so recv_valid) moves one tick later. Undefined: single sample.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   rx                      serial input (asynchronous, synchronised inside)
//   tx                      serial output (registered, idles high)
//   send_data / send_req    word to transmit, accepted when send_ready = 1
//   send_ready              transmitter idle
//   recv_data               last received word, right-justified
//   recv_valid              one-clk pulse per completed frame (errored or not)
//   parity_err / frame_err  error flags for the last frame, held until next
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_ex #(
  parameter int CLK_DIV_COUNT = 216,
  parameter int DIV_WIDTH     = 8,
  parameter int OVS_LOG2      = 2,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic                 tx,
  input  logic [DATA_BITS-1:0] send_data,
  input  logic                 send_req,
  output logic                 send_ready,
  output logic [DATA_BITS-1:0] recv_data,
  output logic                 recv_valid,
  output logic                 parity_err,
  output logic                 frame_err
);

  localparam int OVS = 1 << OVS_LOG2;
  localparam logic [DIV_WIDTH-1:0] DIV_RELOAD  = DIV_WIDTH'(CLK_DIV_COUNT);
  localparam logic [OVS_LOG2-1:0]  RX_BIT_LAST = OVS_LOG2'(OVS - 1);
  localparam logic [3:0]           DATA_LAST   = 4'(DATA_BITS - 1);
  localparam logic [1:0]           STOP_LAST   = 2'(STOP_BITS);
`ifdef UART_RX_MAJORITY_EN
  // Decision one tick after the centre so the centre+1 sample is available.
  localparam logic [OVS_LOG2-1:0]  RX_START_LAST = OVS_LOG2'(OVS / 2);
`else
  localparam logic [OVS_LOG2-1:0]  RX_START_LAST = OVS_LOG2'(OVS / 2 - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  // Parity bit value that makes the frame correct for the configured mode.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    parity_bit = (PARITY == 1) ? ~(^d) : (^d);
  endfunction

  // ---------------------------------------------------------------------------
  // Tick generation
  // ---------------------------------------------------------------------------
  logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
  logic [OVS_LOG2-1:0]  tx_phase_q, tx_phase_d;
  logic                 tick;
  logic                 bit_tick;

  // Divider and free-running tx phase next values.
  always_comb begin
    tick       = (div_cnt_q == {DIV_WIDTH{1'b0}});
    div_cnt_d  = tick ? DIV_RELOAD : (div_cnt_q - DIV_WIDTH'(1));
    tx_phase_d = tick ? (tx_phase_q + OVS_LOG2'(1)) : tx_phase_q;
    bit_tick   = tick && (tx_phase_q == {OVS_LOG2{1'b0}});
  end

  // Divider and phase registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q  <= DIV_RELOAD;
      tx_phase_q <= {OVS_LOG2{1'b0}};
    end else begin
      div_cnt_q  <= div_cnt_d;
      tx_phase_q <= tx_phase_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  state_e               tx_state_q, tx_state_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
  logic                 tx_par_q, tx_par_d;
  logic [3:0]           tx_idx_q, tx_idx_d;
  logic [1:0]           tx_stop_q, tx_stop_d;
  logic                 tx_q, tx_d;
  logic                 send_ready_q, send_ready_d;

  // TX state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q   <= S_IDLE;
      tx_data_q    <= {DATA_BITS{1'b0}};
      tx_par_q     <= 1'b0;
      tx_idx_q     <= 4'd0;
      tx_stop_q    <= 2'd0;
      tx_q         <= 1'b1;
      send_ready_q <= 1'b1;
    end else begin
      tx_state_q   <= tx_state_d;
      tx_data_q    <= tx_data_d;
      tx_par_q     <= tx_par_d;
      tx_idx_q     <= tx_idx_d;
      tx_stop_q    <= tx_stop_d;
      tx_q         <= tx_d;
      send_ready_q <= send_ready_d;
    end
  end

  // TX next state: the state names the next bit to put on the line.
  always_comb begin
    tx_state_d = tx_state_q;
    case (tx_state_q)
      S_IDLE:   if (send_req && send_ready_q) tx_state_d = S_START;
                else                          tx_state_d = S_IDLE;
      S_START:  if (bit_tick) tx_state_d = S_DATA;
                else          tx_state_d = S_START;
      S_DATA:   if (bit_tick && (tx_idx_q == DATA_LAST))
                  tx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                else
                  tx_state_d = S_DATA;
      S_PARITY: if (bit_tick) tx_state_d = S_STOP;
                else          tx_state_d = S_PARITY;
      // The extra stop-count step ends the last stop bit a full period later.
      S_STOP:   if (bit_tick && (tx_stop_q == STOP_LAST)) tx_state_d = S_IDLE;
                else                                      tx_state_d = S_STOP;
      default:  tx_state_d = S_IDLE;
    endcase
  end

  // TX outputs and datapath.
  always_comb begin
    tx_d         = tx_q;
    tx_data_d    = tx_data_q;
    tx_par_d     = tx_par_q;
    tx_idx_d     = tx_idx_q;
    tx_stop_d    = tx_stop_q;
    send_ready_d = send_ready_q;
    case (tx_state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (send_req && send_ready_q) begin
          tx_data_d    = send_data;
          tx_par_d     = parity_bit(send_data);
          tx_idx_d     = 4'd0;
          tx_stop_d    = 2'd0;
          send_ready_d = 1'b0;
        end else begin
          send_ready_d = 1'b1;
        end
      end
      S_START: begin
        if (bit_tick) tx_d = 1'b0;
        else          tx_d = tx_q;
      end
      S_DATA: begin
        if (bit_tick) begin
          tx_d      = tx_data_q[0];
          tx_data_d = tx_data_q >> 1;
          tx_idx_d  = tx_idx_q + 4'd1;
        end else begin
          tx_d = tx_q;
        end
      end
      S_PARITY: begin
        if (bit_tick) tx_d = tx_par_q;
        else          tx_d = tx_q;
      end
      S_STOP: begin
        if (bit_tick && (tx_stop_q == STOP_LAST)) begin
          send_ready_d = 1'b1;
        end else if (bit_tick) begin
          tx_d      = 1'b1;
          tx_stop_d = tx_stop_q + 2'd1;
        end else begin
          tx_d = tx_q;
        end
      end
      default: begin
        tx_d         = 1'b1;
        send_ready_d = 1'b1;
      end
    endcase
  end

  assign tx         = tx_q;
  assign send_ready = send_ready_q;

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  logic                 rx_meta_q, rx_meta_d;
  logic                 rx_sync_q, rx_sync_d;
  logic                 rx_bit_s;
  logic                 rx_centre_s;
  state_e               rx_state_q, rx_state_d;
  logic [OVS_LOG2-1:0]  rx_cnt_q, rx_cnt_d;
  logic [3:0]           rx_idx_q, rx_idx_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_armed_q, rx_armed_d;
  logic [DATA_BITS-1:0] recv_data_q, recv_data_d;
  logic                 recv_valid_q, recv_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
`ifdef UART_RX_MAJORITY_EN
  logic [1:0]           rx_hist_q, rx_hist_d;
`endif

  // Synchroniser, sample history and the value used as "the" sample.
  always_comb begin
    rx_meta_d = rx;
    rx_sync_d = rx_meta_q;
`ifdef UART_RX_MAJORITY_EN
    // hist[1] = two ticks ago (centre-1), hist[0] = last tick (centre).
    rx_hist_d = tick ? {rx_hist_q[0], rx_sync_q} : rx_hist_q;
    rx_bit_s  = (rx_hist_q[1] & rx_hist_q[0]) |
                (rx_hist_q[1] & rx_sync_q)    |
                (rx_hist_q[0] & rx_sync_q);
`else
    rx_bit_s  = rx_sync_q;
`endif
    if (rx_state_q == S_START) rx_centre_s = tick && (rx_cnt_q == RX_START_LAST);
    else                       rx_centre_s = tick && (rx_cnt_q == RX_BIT_LAST);
  end

  // RX state register (synchroniser idles high so a reset never looks like a start).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
      rx_hist_q    <= 2'b11;
`endif
      rx_state_q   <= S_IDLE;
      rx_cnt_q     <= {OVS_LOG2{1'b0}};
      rx_idx_q     <= 4'd0;
      rx_shift_q   <= {DATA_BITS{1'b0}};
      rx_perr_q    <= 1'b0;
      rx_armed_q   <= 1'b0;
      recv_data_q  <= {DATA_BITS{1'b0}};
      recv_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_meta_q    <= rx_meta_d;
      rx_sync_q    <= rx_sync_d;
`ifdef UART_RX_MAJORITY_EN
      rx_hist_q    <= rx_hist_d;
`endif
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_idx_q     <= rx_idx_d;
      rx_shift_q   <= rx_shift_d;
      rx_perr_q    <= rx_perr_d;
      rx_armed_q   <= rx_armed_d;
      recv_data_q  <= recv_data_d;
      recv_valid_q <= recv_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // RX next state.
  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      S_IDLE:   if (tick && rx_armed_q && !rx_sync_q) rx_state_d = S_START;
                else                                  rx_state_d = S_IDLE;
      // A start bit that is high again at its centre was only a glitch.
      S_START:  if (rx_centre_s) rx_state_d = rx_bit_s ? S_IDLE : S_DATA;
                else             rx_state_d = S_START;
      S_DATA:   if (rx_centre_s && (rx_idx_q == DATA_LAST))
                  rx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                else
                  rx_state_d = S_DATA;
      S_PARITY: if (rx_centre_s) rx_state_d = S_STOP;
                else             rx_state_d = S_PARITY;
      S_STOP:   if (rx_centre_s) rx_state_d = S_IDLE;
                else             rx_state_d = S_STOP;
      default:  rx_state_d = S_IDLE;
    endcase
  end

  // RX outputs and datapath.
  always_comb begin
    rx_cnt_d     = rx_cnt_q;
    rx_idx_d     = rx_idx_q;
    rx_shift_d   = rx_shift_q;
    rx_perr_d    = rx_perr_q;
    rx_armed_d   = rx_armed_q;
    recv_data_d  = recv_data_q;
    recv_valid_d = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;

    if (rx_state_q == S_IDLE)  rx_cnt_d = {OVS_LOG2{1'b0}};
    else if (rx_centre_s)      rx_cnt_d = {OVS_LOG2{1'b0}};
    else if (tick)             rx_cnt_d = rx_cnt_q + OVS_LOG2'(1);
    else                       rx_cnt_d = rx_cnt_q;

    case (rx_state_q)
      S_IDLE: begin
        // Only a line seen high can arm detection; this swallows a held break.
        if (rx_sync_q) rx_armed_d = 1'b1;
        else           rx_armed_d = rx_armed_q;
      end
      S_START: begin
        if (rx_centre_s) begin
          rx_idx_d  = 4'd0;
          rx_perr_d = 1'b0;
        end else begin
          rx_idx_d  = rx_idx_q;
        end
      end
      S_DATA: begin
        if (rx_centre_s) begin
          rx_shift_d = {rx_bit_s, rx_shift_q[DATA_BITS-1:1]};
          rx_idx_d   = rx_idx_q + 4'd1;
        end else begin
          rx_shift_d = rx_shift_q;
        end
      end
      S_PARITY: begin
        if (rx_centre_s) rx_perr_d = rx_bit_s ^ parity_bit(rx_shift_q);
        else             rx_perr_d = rx_perr_q;
      end
      S_STOP: begin
        if (rx_centre_s) begin
          recv_data_d  = rx_shift_q;
          recv_valid_d = 1'b1;
          parity_err_d = (PARITY != 0) ? rx_perr_q : 1'b0;
          frame_err_d  = ~rx_bit_s;
          rx_armed_d   = rx_bit_s;
        end else begin
          recv_valid_d = 1'b0;
        end
      end
      default: begin
        recv_valid_d = 1'b0;
      end
    endcase
  end

  assign recv_data  = recv_data_q;
  assign recv_valid = recv_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;

endmodule
